// File: rtl/led7seg_pkg.sv
// Shared definitions for the 7-segment scan stage: FSM states, blank code, digit count, digit-select encoder.
// Latency: none (declarations only).
// Backpressure: none.
package led7seg_pkg;

    typedef enum logic [1:0] {
        WAIT_TICK = 2'd0,
        WAIT_RDY  = 2'd1,
        ISSUE     = 2'd2
    } scan_state_t;

    // Active-low segments: all ones means every segment is dark.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         N_DIGITS  = 4;
    localparam int         DIG_W     = $clog2(N_DIGITS);

    // Digit index -> active-low one-hot select byte for the digit 74HC595.
    function automatic logic [7:0] digit_sel(input logic [DIG_W-1:0] idx);
        logic [7:0] sel;
        sel      = 8'hFF;
        sel[idx] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/led7seg_scan_mux_if.sv
// Bundle of the frame handshake and hc595_driver word port of the scan mux.
// Latency: none (wiring only).
// Backpressure: frame_ready on the frame side, drv_rdy on the driver side.
interface led7seg_scan_mux_if;
    // Frame side: 4 active-low segment codes, dig_0 in [31:24], plus blanking.
    logic        frame_valid;
    logic        frame_ready;
    logic [31:0] seg_frame;
    logic [3:0]  blank_mask;
    // Driver side: one 16-bit {seg, sel} word per digit.
    logic        drv_rdy;
    logic        drv_start;
    logic [15:0] drv_data;
    // Status.
    logic [1:0]  cur_digit;
    logic [7:0]  overrun;

    // master: frame producer + driver + status observer; slave: the scan mux.
    modport master (
        output frame_valid, seg_frame, blank_mask, drv_rdy,
        input  frame_ready, drv_start, drv_data, cur_digit, overrun
    );
    modport slave (
        input  frame_valid, seg_frame, blank_mask, drv_rdy,
        output frame_ready, drv_start, drv_data, cur_digit, overrun
    );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick for one cycle at terminal count.
// Latency: first tick DIV cycles after reset release, then every DIV cycles.
// Backpressure: none; ticks are never held or queued.
module tick_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/led7seg_scan_mux.sv
// 4-digit multiplexed scan: double-buffers a 32-bit segment frame, issues one {seg, sel} word per digit per scan tick.
// Latency: drv_start 2 cycles after a scan tick when drv_rdy is high; a new frame shows from the next digit-0 issue.
// Backpressure: frame_ready low while a frame is pending; waits on drv_rdy; ticks arriving while busy are dropped and counted.
module led7seg_scan_mux
    import led7seg_pkg::*;
#(
    parameter int input_clk_freq = 100_000_000,
    parameter int scan_freq      = 1000
) (
    input logic               clk,
    input logic               rst_n,
    led7seg_scan_mux_if.slave bus
);

    // Must stay >= 64 so a 16-bit word is fully shifted out before the next tick.
    localparam int SCAN_DIV = input_clk_freq / scan_freq;

    scan_state_t      state_q, state_d;
    logic [DIG_W-1:0] cur_q;
    logic [DIG_W-1:0] next_idx;
    logic [15:0]      data_q;
    logic [31:0]      act_frame_q, pend_frame_q;
    logic [3:0]       act_blank_q, pend_blank_q;
    logic             pend_q;
    logic             copy_q;
    logic [7:0]       ovr_q;
    logic             tick;
    logic             load;
    logic             accept;
    logic             take_pend;
    logic [31:0]      src_frame;
    logic [3:0]       src_blank;
    logic [7:0]       seg_byte;

    tick_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // cur_q only changes on issue, so cur_q+1 equals the digit chosen at the tick.
    assign next_idx  = cur_q + DIG_W'(1);
    assign accept    = bus.frame_valid && !pend_q;
    // Swap buffers only when starting a new pass at digit 0 so a frame never tears.
    assign take_pend = load && (next_idx == '0) && pend_q;
    assign src_frame = take_pend ? pend_frame_q : act_frame_q;
    assign src_blank = take_pend ? pend_blank_q : act_blank_q;
    // dig_0 sits in the top byte, so digit i starts at bit 8*(3-i) == {~i, 3'b000}.
    assign seg_byte  = src_blank[next_idx] ? SEG_BLANK : src_frame[{~next_idx, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            WAIT_TICK: begin
                if (tick) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (bus.drv_rdy) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end
            end
            ISSUE:   state_d = WAIT_TICK;
            default: state_d = WAIT_TICK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_TICK;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word and digit index are registered on entry to ISSUE, so they
    // are valid during the drv_start cycle and hold until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= 16'hFFFF;
            cur_q       <= DIG_W'(N_DIGITS - 1);
            act_frame_q <= 32'hFFFF_FFFF;
            act_blank_q <= '0;
            copy_q      <= 1'b0;
        end else begin
            copy_q <= take_pend;
            if (load) begin
                data_q <= {seg_byte, digit_sel(next_idx)};
                cur_q  <= next_idx;
            end
            if (take_pend) begin
                act_frame_q <= pend_frame_q;
                act_blank_q <= pend_blank_q;
            end
        end
    end

    // Pending buffer. The clear is delayed one cycle behind the copy, so
    // frame_ready rises the cycle after the digit-0 issue. copy_q and accept
    // are exclusive because copy_q implies pend_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 1'b0;
            pend_frame_q <= 32'hFFFF_FFFF;
            pend_blank_q <= '0;
        end else if (copy_q) begin
            pend_q <= 1'b0;
        end else if (accept) begin
            pend_q       <= 1'b1;
            pend_frame_q <= bus.seg_frame;
            pend_blank_q <= bus.blank_mask;
        end
    end

    // A tick outside WAIT_TICK is lost; count it, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else if (tick && (state_q != WAIT_TICK) && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 8'd1;
        end
    end

    assign bus.frame_ready = !pend_q;
    assign bus.drv_start   = (state_q == ISSUE);
    assign bus.drv_data    = data_q;
    assign bus.cur_digit   = cur_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_led7seg_scan_mux.sv
// Bench for led7seg_scan_mux with SCAN_DIV = 100: event-time model checked every cycle plus literal scenario checks.
// Latency: n/a.
// Backpressure: drives frame_valid and drv_rdy directly.
module tb_led7seg_scan_mux;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    led7seg_scan_mux_if bus();

    led7seg_scan_mux #(
        .input_clk_freq (100_000),
        .scan_freq      (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: cycles counted from reset release ----------------
    int          k;                 // cycle index; k=0 is the cycle reset releases in
    bit          in_rst = 1'b1;
    bit          m_waiting;         // a tick was taken, word not yet issued
    int          m_wait_from;
    int          m_issue_at;        // cycle in which drv_start must be high
    int          m_cur;
    int          m_ovr;
    logic [31:0] m_act;
    logic [3:0]  m_abl;
    bit          m_pend;
    logic [31:0] m_pfr;
    logic [3:0]  m_pbl;
    int          m_clr_at;
    logic [15:0] m_data;

    logic [15:0] iss_dat [0:63];
    int          iss_cyc [0:63];
    int          n_iss;

    task automatic model_reset();
        in_rst      = 1'b1;
        k           = 0;
        m_waiting   = 1'b0;
        m_wait_from = 0;
        m_issue_at  = -1;
        m_cur       = 3;
        m_ovr       = 0;
        m_act       = 32'hFFFF_FFFF;
        m_abl       = 4'h0;
        m_pend      = 1'b0;
        m_pfr       = 32'hFFFF_FFFF;
        m_pbl       = 4'h0;
        m_clr_at    = -1;
        m_data      = 16'hFFFF;
        n_iss       = 0;
    endtask

    // Advance the model by the clock edge that ends cycle k.
    task automatic model_step();
        bit         busy;
        int         nxt;
        logic [7:0] seg;
        busy = m_waiting || (m_issue_at == k);
        if (k % 100 == 99) begin
            if (busy) begin
                if (m_ovr < 255) m_ovr++;
            end else begin
                m_waiting   = 1'b1;
                m_wait_from = k + 1;
            end
        end
        if (m_waiting && k >= m_wait_from && bus.drv_rdy) begin
            m_waiting  = 1'b0;
            m_issue_at = k + 1;
            nxt        = (m_cur + 1) % 4;
            if (nxt == 0 && m_pend) begin
                m_act    = m_pfr;
                m_abl    = m_pbl;
                m_clr_at = k + 2;
            end
            seg    = m_abl[nxt] ? 8'hFF : m_act[31 - 8*nxt -: 8];
            m_data = {seg, ~(8'h01 << nxt)};
            m_cur  = nxt;
        end
        if (bus.frame_valid && !m_pend) begin
            m_pend = 1'b1;
            m_pfr  = bus.seg_frame;
            m_pbl  = bus.blank_mask;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (in_rst) begin
                in_rst = 1'b0;
                k      = 0;
            end else begin
                k = k + 1;
            end
            if (m_clr_at == k) m_pend = 1'b0;
            chk("drv_start",   32'(bus.drv_start),   32'(m_issue_at == k));
            chk("drv_data",    32'(bus.drv_data),    32'(m_data));
            chk("cur_digit",   32'(bus.cur_digit),   32'(m_cur));
            chk("frame_ready", 32'(bus.frame_ready), 32'(!m_pend));
            chk("overrun",     32'(bus.overrun),     32'(m_ovr));
            if (bus.drv_start && n_iss < 64) begin
                iss_dat[n_iss] = bus.drv_data;
                iss_cyc[n_iss] = k;
                n_iss++;
            end
            model_step();
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic wait_iss(input int n, input int budget);
        int t = 0;
        while (n_iss < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        if (n_iss < n) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_issue_%0d: got %0d issues, expected %0d", n, n_iss, n);
        end
    endtask

    task automatic wait_k(input int target, input int budget);
        int t = 0;
        while (k < target && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        if (k < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_cycle_%0d: got cycle %0d, expected %0d", target, k, target);
        end
    endtask

    task automatic offer(input logic [31:0] f, input logic [3:0] b, output int acc_k);
        int t    = 0;
        bit done = 1'b0;
        acc_k = -1;
        @(posedge clk); #1;
        bus.frame_valid = 1'b1;
        bus.seg_frame   = f;
        bus.blank_mask  = b;
        while (!done && t < 1000) begin
            @(negedge clk); #1;
            if (bus.frame_ready) begin
                acc_k = k;
                done  = 1'b1;
            end
            t++;
        end
        @(posedge clk); #1;
        bus.frame_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL offer_timeout: got no frame_ready, expected 1");
        end
    endtask

    // ---------------- directed scenario ----------------
    initial begin
        int acc;
        bus.frame_valid = 1'b0;
        bus.seg_frame   = 32'hFFFF_FFFF;
        bus.blank_mask  = 4'h0;
        bus.drv_rdy     = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_drv_start",   32'(bus.drv_start),   32'h0);
        chk("rst_drv_data",    32'(bus.drv_data),    32'hFFFF);
        chk("rst_cur_digit",   32'(bus.cur_digit),   32'h3);
        chk("rst_frame_ready", 32'(bus.frame_ready), 32'h1);
        chk("rst_overrun",     32'(bus.overrun),     32'h0);
        rst_n = 1'b1;

        // Blank sweep over all four digits.
        wait_iss(4, 500);
        chk("iss0_cyc", iss_cyc[0], 101);
        chk("iss0_dat", 32'(iss_dat[0]), 32'hFFFE);
        chk("iss1_cyc", iss_cyc[1], 201);
        chk("iss1_dat", 32'(iss_dat[1]), 32'hFFFD);
        chk("iss2_dat", 32'(iss_dat[2]), 32'hFFFB);
        chk("iss3_cyc", iss_cyc[3], 401);
        chk("iss3_dat", 32'(iss_dat[3]), 32'hFFF7);

        // "0123" accepted while digit 1 is showing; then a blanked copy queued behind it.
        wait_iss(6, 300);
        offer(32'hC0F9A4B0, 4'b0000, acc);
        chk("acc1_cyc", acc, 602);
        chk("ready_low_after_accept", 32'(bus.frame_ready), 32'h0);
        offer(32'hC0F9A4B0, 4'b1000, acc);
        chk("acc2_cyc_after_copy", acc, 902);

        wait_iss(16, 1000);
        chk("iss6_dat",  32'(iss_dat[6]),  32'hFFFB);
        chk("iss7_dat",  32'(iss_dat[7]),  32'hFFF7);
        chk("iss8_cyc",  iss_cyc[8], 901);
        chk("iss8_dat",  32'(iss_dat[8]),  32'hC0FE);
        chk("iss9_dat",  32'(iss_dat[9]),  32'hF9FD);
        chk("iss10_dat", 32'(iss_dat[10]), 32'hA4FB);
        chk("iss11_dat", 32'(iss_dat[11]), 32'hB0F7);
        chk("iss12_dat", 32'(iss_dat[12]), 32'hC0FE);
        chk("iss15_dat", 32'(iss_dat[15]), 32'hFFF7);

        // Driver busy for 350 cycles spanning four ticks: first waits, three drop.
        wait_k(1697, 200);
        @(posedge clk); #1;
        bus.drv_rdy = 1'b0;
        repeat (350) @(posedge clk);
        #1;
        bus.drv_rdy = 1'b1;
        chk("overrun_after_stall", 32'(bus.overrun), 32'h3);
        chk("no_issue_during_stall", n_iss, 16);
        wait_iss(18, 300);
        chk("iss16_cyc", iss_cyc[16], 2049);
        chk("iss16_dat", 32'(iss_dat[16]), 32'hC0FE);
        chk("iss17_cyc", iss_cyc[17], 2101);
        chk("iss17_dat", 32'(iss_dat[17]), 32'hF9FD);

        // Reset while stuck in WAIT_RDY with a frame pending.
        offer(32'h12345678, 4'b0000, acc);
        @(posedge clk); #1;
        bus.drv_rdy = 1'b0;
        wait_k(2250, 300);
        chk("pre_rst_frame_ready", 32'(bus.frame_ready), 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drv_data",    32'(bus.drv_data),    32'hFFFF);
        chk("mid_rst_frame_ready", 32'(bus.frame_ready), 32'h1);
        chk("mid_rst_overrun",     32'(bus.overrun),     32'h0);
        chk("mid_rst_cur_digit",   32'(bus.cur_digit),   32'h3);
        chk("mid_rst_drv_start",   32'(bus.drv_start),   32'h0);
        @(posedge clk); #1;
        bus.drv_rdy = 1'b1;
        rst_n       = 1'b1;
        wait_iss(1, 300);
        chk("restart_cyc", iss_cyc[0], 101);
        chk("restart_dat", 32'(iss_dat[0]), 32'hFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/led7seg_scan_mux.md
Name: led7seg_scan_mux

Overview:
- Multiplexed scan stage for a 4-digit common-anode 7-segment display wired through two chained 74HC595s: one for segments, one for digit select.
- Sits between the bcd_to_led7seg encoders and the hc595_driver.
- Accepts a 32-bit segment frame through a valid/ready handshake and double-buffers it.
- At a fixed scan rate, hands one 16-bit word per digit to the hc595_driver (driver configured with N=16).

Parameters:
- input_clk_freq, 100_000_000, input clock frequency in Hz.
- scan_freq, 1000, digit-advance rate in Hz; full-frame refresh is scan_freq/4.
- SCAN_DIV, input_clk_freq/scan_freq, derived prescaler terminal count; must be >= 64 (serialisation time).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_valid, input, 1, new frame present on seg_frame.
- frame_ready, output, 1, pending buffer empty; frame accepted when frame_valid && frame_ready.
- seg_frame, input, 32, {dig_0, dig_1, dig_2, dig_3} 7-seg codes, active-low; dig_0 in [31:24].
- blank_mask, input, 4, bit i=1 forces digit i dark; sampled with seg_frame.
- drv_rdy, input, 1, hc595_driver idle / ready for a word.
- drv_start, output, 1, one-cycle pulse that launches a driver transfer (drives en_input).
- drv_data, output, 16, {seg[7:0], sel[7:0]}; held stable from the drv_start cycle until the next drv_start.
- cur_digit, output, 2, index of the digit most recently issued.
- overrun, output, 8, saturating count of scan ticks dropped because the driver was busy.

Behaviour:
- Reset (async, rst_n=0):
  - drv_start=0, drv_data=16'hFFFF (all segments off, no digit selected).
  - cur_digit=3, so the first issued digit is 0.
  - frame_ready=1, overrun=0, active buffer=32'hFFFF_FFFF, pending flag=0, prescaler=0, FSM=WAIT_TICK.
- Frame buffering:
  - On accept, seg_frame and blank_mask are written to the pending buffer, pending=1, frame_ready=0 from the next cycle.
  - Pending is copied to the active buffer only when the next digit to issue is 0 (i.e. cur_digit==3 at issue time). Frames never tear mid-scan.
  - Copy takes effect for that same digit 0; pending clears and frame_ready returns to 1 in the following cycle.
  - Accept and copy can occur in the same cycle only if pending was already 1. They cannot collide because frame_ready=0 whenever pending=1.
- Prescaler:
  - Counts 0..SCAN_DIV-1, free-running.
  - scan_tick is a one-cycle pulse at terminal count.
- FSM:
  - WAIT_TICK: on scan_tick, next = cur_digit+1 (mod 4, wraps 3->0); go to WAIT_RDY.
  - WAIT_RDY: when drv_rdy=1, go to ISSUE.
  - ISSUE (one cycle):
    - drv_start=1.
    - drv_data seg = 8'hFF if the blank bit is set, else the active byte for digit next.
    - drv_data sel = 8'hFF with bit next cleared (one-hot active-low).
    - cur_digit=next; return to WAIT_TICK.
  - Latency from scan_tick to drv_start is 2 cycles when drv_rdy is already high.
- Overrun:
  - A scan_tick arriving while in WAIT_RDY or ISSUE is dropped; the digit does not advance twice.
  - overrun increments and saturates at 255.
- Reset mid-transfer: outputs return to reset values immediately. A driver transfer already in flight is not aborted by this block.

Decomposition:
- Shared package led7seg_pkg holds:
  - FSM state encoding (WAIT_TICK, WAIT_RDY, ISSUE).
  - SEG_BLANK=8'hFF.
  - N_DIGITS=4.
  - Digit-select helper function (index -> active-low one-hot).
- One sub-module: tick_prescaler (parameter DIV; ports clk, rst_n, tick). It is reusable by clk_divider users.
- Frame buffer and FSM stay in the top-level scan module.

Test Plan:
- Reset release, no frame, drv_rdy=1, scan_freq chosen so SCAN_DIV=100 -> first drv_start 101 cycles after reset release with drv_data=16'hFFFE (seg FF, digit 0); digits 1..3 follow at 100-cycle spacing with sel FD, FB, F7.
- Accept frame 32'hC0F9A4B0 ("0123") while digit 1 is active -> digits 2, 3 still FF; next digit 0 shows seg C0; frame_ready returns to 1 one cycle after that issue.
- Second frame offered while pending=1 -> frame_ready=0 and no accept; accept occurs only after the copy at the wrap to digit 0.
- blank_mask=4'b1000 with frame "0123" -> digit 3 issued with seg FF, sel F7; other digits carry their codes.
- Hold drv_rdy=0 for 350 cycles -> 3 ticks dropped, overrun=3; on drv_rdy=1, exactly one issue for the next digit, with no skipped index.
- Assert rst_n=0 during WAIT_RDY -> drv_data=FFFF, frame_ready=1, overrun=0 asynchronously; after release the sequence restarts at digit 0.
